serial_subtractor_ctrl: RTL and testbench

// - Bit-serial subtract controller: sequences a single 1-bit full-subtractor cell over WIDTH bits, LSB first.
// - Computes diff = a - b - bin and the final borrow, using one cell instead of a WIDTH-bit ripple chain.
// - Sits between an operand producer (in_valid/in_ready) and a result consumer (out_valid/out_ready).

---
 rtl/serial_subtractor_ctrl.sv | 126 ++++++++++++
 tb/tb_serial_subtractor_ctrl.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor_ctrl.sv
// Bit-serial subtractor: one full-subtractor cell stepped over WIDTH bits, LSB first.
// Optional signed-overflow output is enabled by defining SERIAL_SUB_OVF_EN.
module serial_subtractor_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             busy
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_res;
    logic             r_br;
    logic [CW-1:0]    r_cnt;
`ifdef SERIAL_SUB_OVF_EN
    logic             r_am;
    logic             r_bm;
`endif

    logic             w_a0;
    logic             w_b0;
    logic             w_d;
    logic             w_br;
    logic             w_last;
    logic [WIDTH-1:0] w_res_nxt;

    // Single full-subtractor cell working on the current LSBs
    assign w_a0      = r_a[0];
    assign w_b0      = r_b[0];
    assign w_d       = w_a0 ^ w_b0 ^ r_br;
    assign w_br      = (~w_a0 & w_b0) | (~(w_a0 ^ w_b0) & r_br);
    assign w_last    = (r_cnt == CW'(WIDTH - 1));
    assign w_res_nxt = {w_d, r_res[WIDTH-1:1]};

    // Control FSM with all datapath and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_a       <= '0;
            r_b       <= '0;
            r_res     <= '0;
            r_br      <= 1'b0;
            r_cnt     <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            diff      <= '0;
            borrow    <= 1'b0;
            busy      <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            r_am      <= 1'b0;
            r_bm      <= 1'b0;
            ovf       <= 1'b0;
`endif
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (in_valid && in_ready) begin
                        r_a      <= a;
                        r_b      <= b;
                        r_br     <= bin;
                        r_res    <= '0;
                        r_cnt    <= '0;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        r_state  <= S_RUN;
`ifdef SERIAL_SUB_OVF_EN
                        r_am     <= a[WIDTH-1];
                        r_bm     <= b[WIDTH-1];
`endif
                    end
                end
                S_RUN: begin
                    r_a   <= r_a >> 1;
                    r_b   <= r_b >> 1;
                    r_br  <= w_br;
                    r_res <= w_res_nxt;
                    r_cnt <= r_cnt + CW'(1);
                    if (w_last) begin
                        r_state   <= S_DONE;
                        out_valid <= 1'b1;
                        diff      <= w_res_nxt;
                        borrow    <= w_br;
`ifdef SERIAL_SUB_OVF_EN
                        ovf       <= (r_am ^ r_bm) & (r_am ^ w_d);
`endif
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_state   <= S_IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor_ctrl.sv
// Scoreboard bench for serial_subtractor_ctrl at WIDTH=8.
// Expected results are queued on accept and compared on result handshake.
module tb_serial_subtractor_ctrl;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] diff;
    logic         borrow;
    logic         busy;
`ifdef SERIAL_SUB_OVF_EN
    logic         ovf;
`endif

    typedef struct {
        logic [W-1:0] d;
        logic         br;
        logic         ov;
    } exp_t;

    exp_t q[$];
    int   tests;
    int   fails;
    int   cyc;
    int   last_acc;
    bit   have_last;
    bit   gap_chk;

    serial_subtractor_ctrl #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .bin       (bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .borrow    (borrow),
        .busy      (busy)
`ifdef SERIAL_SUB_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] ta,
                                   input logic [W-1:0] tb,
                                   input logic tbin);
        exp_t        e;
        logic [W:0]  r;
        r    = {1'b0, ta} - {1'b0, tb} - {{W{1'b0}}, tbin};
        e.d  = r[W-1:0];
        e.br = r[W];
        e.ov = (ta[W-1] ^ tb[W-1]) & (ta[W-1] ^ r[W-1]);
        return e;
    endfunction

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (cyc > 20000) begin
            $display("FAIL watchdog: got %0d cycles expected < 20000", cyc);
            $fatal(1);
        end
    end

    // Push the expected result whenever an operand handshake is seen
    always @(negedge clk) begin
        if (rst_n && in_valid && in_ready) begin
            q.push_back(model(a, b, bin));
            if (gap_chk && have_last)
                chk("issue_gap", 64'(cyc - last_acc), 64'd10);
            last_acc  = cyc;
            have_last = 1'b1;
        end
    end

    // Pop and compare whenever a result handshake is seen
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && out_valid && out_ready) begin
            if (q.size() == 0) begin
                chk("sb_unexpected", 64'd1, 64'd0);
            end else begin
                e = q.pop_front();
                chk("diff", 64'(diff), 64'(e.d));
                chk("borrow", 64'(borrow), 64'(e.br));
`ifdef SERIAL_SUB_OVF_EN
                chk("ovf", 64'(ovf), 64'(e.ov));
`endif
            end
        end
    end

    task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb,
                        input logic tbin);
        int n;
        n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) chk("ready_timeout", 64'd0, 64'd1);
        a        = ta;
        b        = tb;
        bin      = tbin;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("latency", 64'(n), 64'(W));
        n = 0;
        while (out_valid && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (out_valid) chk("drain_timeout", 64'd0, 64'd1);
    endtask

    initial begin
        logic [W-1:0] hold_d;
        logic [W-1:0] ta;
        logic [W-1:0] tb;
        int           n;
        tests     = 0;
        fails     = 0;
        cyc       = 0;
        last_acc  = 0;
        have_last = 1'b0;
        gap_chk   = 1'b0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a         = '0;
        b         = '0;
        bin       = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_diff", 64'(diff), 64'd0);
        chk("rst_borrow", 64'(borrow), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        send(8'h5A, 8'h3C, 1'b0);
        send(8'h00, 8'h01, 1'b0);
        send(8'h10, 8'h0F, 1'b1);
        send(8'h80, 8'h01, 1'b0);
        send(8'h05, 8'h03, 1'b0);
        send(8'hFF, 8'hFF, 1'b1);
        send(8'h7F, 8'h80, 1'b0);
        for (int i = 0; i < 8; i++)
            send(8'($urandom), 8'($urandom), 1'($urandom));

        // Hold the result in DONE while the consumer stalls
        out_ready = 1'b0;
        a         = 8'h33;
        b         = 8'h44;
        bin       = 1'b1;
        in_valid  = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("hold_latency", 64'(n), 64'(W));
        hold_d = diff;
        chk("hold_diff0", 64'(diff), 64'(model(8'h33, 8'h44, 1'b1).d));
        for (int i = 0; i < 5; i++) begin
            a        = 8'hC3;
            b        = 8'h01;
            in_valid = (i == 2);
            @(negedge clk);
            chk("hold_valid", 64'(out_valid), 64'd1);
            chk("hold_ready", 64'(in_ready), 64'd0);
            chk("hold_diff", 64'(diff), 64'(hold_d));
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("rel_in_ready", 64'(in_ready), 64'd1);
        chk("rel_out_valid", 64'(out_valid), 64'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("no_capture_busy", 64'(busy), 64'd0);
        chk("no_capture_q", 64'(q.size()), 64'd0);

        // Back-to-back issue with the consumer always ready
        gap_chk   = 1'b1;
        have_last = 1'b0;
        in_valid  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            ta = 8'($urandom);
            tb = 8'($urandom);
            a   = ta;
            b   = tb;
            bin = 1'(i);
            n = 0;
            while (!in_ready && n < 30) begin
                @(posedge clk); #1;
                n++;
            end
            if (!in_ready) chk("b2b_timeout", 64'd0, 64'd1);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        gap_chk  = 1'b0;
        n = 0;
        while ((q.size() != 0 || busy) && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        chk("b2b_drain", 64'(q.size()), 64'd0);

        // Abort mid-operation with an asynchronous reset
        a        = 8'hFF;
        b        = 8'h01;
        bin      = 1'b0;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        q.delete();
        chk("abort_out_valid", 64'(out_valid), 64'd0);
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_in_ready", 64'(in_ready), 64'd1);
        chk("abort_diff", 64'(diff), 64'd0);
        chk("abort_borrow", 64'(borrow), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        send(8'h03, 8'h05, 1'b0);

        chk("final_q_empty", 64'(q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
